// File: rtl/rng_uni_seeder.sv
// rng_uni_seeder: seed-load controller for the 32-bit uniform LUT-SR generator.
// Accepts WORDS x 32-bit seed words over valid/ready, shifts each word LSB-first
// into the generator's 1024-bit serial-load chain, runs WARMUP free-run cycles,
// then flags the generator output as usable.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   seed_start               request reseed (honoured in IDLE or RUN)
//   seed_data/valid/ready    seed word handshake, bit 0 shifted first
//   run_en                   user ce request while in RUN
//   rng_mode/ce/s_in         generator serial-load controls
//   rng_s_out                generator scan output
//   busy                     loading or warming up
//   rng_ok                   generator seeded and warmed up
//   rb_data/rb_valid         previous chain contents, one word per pulse
//                            (only with RNG_UNI_SEEDER_READBACK_EN defined)
//
// Optional feature macro: RNG_UNI_SEEDER_READBACK_EN
module rng_uni_seeder #(
  parameter int unsigned WORDS  = 32,
  parameter int unsigned WARMUP = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_start,
  input  logic [31:0] seed_data,
  input  logic        seed_valid,
  output logic        seed_ready,
  input  logic        run_en,
  output logic        rng_mode,
  output logic        rng_ce,
  output logic        rng_s_in,
  input  logic        rng_s_out,
  output logic        busy,
  output logic        rng_ok
`ifdef RNG_UNI_SEEDER_READBACK_EN
  ,
  output logic [31:0] rb_data,
  output logic        rb_valid
`endif
);

  localparam int unsigned WCW = $clog2(WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_SHIFT,
    S_WARMUP,
    S_RUN
  } state_t;

  state_t         state, state_n;
  logic [WCW-1:0] word_cnt, word_n;
  logic [4:0]     bit_cnt, bit_n;
  logic [15:0]    warm_cnt, warm_n;
  logic [31:0]    shreg, shreg_n;
  logic           ce_q;
  logic           ready_n, mode_n, ce_n, s_in_n, busy_n, ok_n;

  // In RUN the generator ce follows the user request directly.
  assign rng_ce = (state == S_RUN) ? run_en : ce_q;

  // Next-state, counters and next registered output values.
  always_comb begin
    state_n = state;
    word_n  = word_cnt;
    bit_n   = bit_cnt;
    warm_n  = warm_cnt;
    shreg_n = shreg;
    s_in_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (seed_start) begin
          state_n = S_LOAD_WAIT;
          word_n  = '0;
        end
      end
      S_LOAD_WAIT: begin
        if (seed_valid && seed_ready) begin
          // Bit 0 goes straight to s_in; shreg keeps the bits still to send.
          state_n = S_SHIFT;
          s_in_n  = seed_data[0];
          shreg_n = {1'b0, seed_data[31:1]};
          bit_n   = '0;
        end
      end
      S_SHIFT: begin
        s_in_n  = shreg[0];
        shreg_n = shreg >> 1;
        bit_n   = bit_cnt + 5'd1;
        if (bit_cnt == 5'd31) begin
          s_in_n = 1'b0;
          word_n = word_cnt + WCW'(1);
          warm_n = '0;
          state_n = (word_cnt + WCW'(1) == WCW'(WORDS)) ? S_WARMUP : S_LOAD_WAIT;
        end
      end
      S_WARMUP: begin
        if (warm_cnt == 16'(WARMUP - 1)) state_n = S_RUN;
        else warm_n = warm_cnt + 16'd1;
      end
      S_RUN: begin
        if (seed_start) begin
          state_n = S_LOAD_WAIT;
          word_n  = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
    ready_n = (state_n == S_LOAD_WAIT);
    mode_n  = (state_n == S_SHIFT);
    ce_n    = (state_n == S_SHIFT) || (state_n == S_WARMUP);
    busy_n  = (state_n == S_LOAD_WAIT) || (state_n == S_SHIFT) || (state_n == S_WARMUP);
    ok_n    = (state_n == S_RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      word_cnt   <= '0;
      bit_cnt    <= '0;
      warm_cnt   <= '0;
      shreg      <= '0;
      seed_ready <= 1'b0;
      rng_mode   <= 1'b0;
      ce_q       <= 1'b0;
      rng_s_in   <= 1'b0;
      busy       <= 1'b0;
      rng_ok     <= 1'b0;
    end else begin
      state      <= state_n;
      word_cnt   <= word_n;
      bit_cnt    <= bit_n;
      warm_cnt   <= warm_n;
      shreg      <= shreg_n;
      seed_ready <= ready_n;
      rng_mode   <= mode_n;
      ce_q       <= ce_n;
      rng_s_in   <= s_in_n;
      busy       <= busy_n;
      rng_ok     <= ok_n;
    end
  end

`ifdef RNG_UNI_SEEDER_READBACK_EN
  // Scan-out capture: old chain bits leave on s_out while the new seed enters.
  // Only 31 bits are held; the 32nd arrives on the completing edge.
  logic [30:0] cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (state == S_SHIFT) begin
        cap <= {rng_s_out, cap[30:1]};
        if (bit_cnt == 5'd31) begin
          rb_data  <= {rng_s_out, cap};
          rb_valid <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_s_out;
  assign unused_s_out = rng_s_out;
`endif

endmodule
